// File: rtl/matrix_row_driver.sv
// Row driver for a 5-column LED matrix with mirrored column pairs.
// Define MATRIX_ROW_ACTIVE_LOW_EN for inverted (active-low) row outputs.
module matrix_row_driver #(
   parameter int ROWS         = 7,
   parameter int BLANK_CYCLES = 2
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [2:0]          col,
   input  logic                load_valid,
   input  logic [3*ROWS-1:0]   load_data,
   output logic                load_ready,
   output logic [ROWS-1:0]     row,
   output logic                frame_start,
   output logic                blanking
);

   localparam int CW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
   localparam logic [CW-1:0] RELOAD =
      CW'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      DRIVE
   } state_t;

   state_t              state;
   state_t              state_d;
   logic [CW-1:0]       cnt;
   logic [CW-1:0]       cnt_d;
   logic [2:0]          col_q;
   logic [3*ROWS-1:0]   active;
   logic [3*ROWS-1:0]   active_d;
   logic [3*ROWS-1:0]   shadow;
   logic                pending;
   logic [ROWS-1:0]     row_q;
   logic [ROWS-1:0]     row_d;
   logic                valid;
   logic                change;
   logic                boundary;
   logic                accept;
   logic                swap;

   function automatic logic [ROWS-1:0] pick(
      input logic [3*ROWS-1:0] pat,
      input logic [2:0]        c
   );
      pick = '0;
      unique case (1'b1)
         c[2]:    pick = pat[2*ROWS +: ROWS];
         c[1]:    pick = pat[ROWS +: ROWS];
         c[0]:    pick = pat[0 +: ROWS];
         default: pick = '0;
      endcase
   endfunction

   assign valid      = $onehot(col);
   assign change     = valid && (col != col_q);
   assign boundary   = change && (col == 3'b100);
   assign accept     = load_valid && !pending;
   assign swap       = boundary && pending;
   assign load_ready = !pending;
   assign blanking   = (state != DRIVE);
   assign active_d   = swap ? shadow : active;

   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      row_d   = '0;
      if (!valid) begin
         state_d = IDLE;
      end else begin
         case (state)
            IDLE, DRIVE: begin
               if (change) begin
                  state_d = (BLANK_CYCLES == 0) ? DRIVE : BLANK;
                  cnt_d   = RELOAD;
               end
            end
            BLANK: begin
               if (change) begin
                  cnt_d = RELOAD;
               end else if (cnt == '0) begin
                  state_d = DRIVE;
               end else begin
                  cnt_d = cnt - CW'(1);
               end
            end
            default: state_d = IDLE;
         endcase
      end
      // Row data is taken from the post-edge column and buffer so that
      // a swap and the first driven slice line up on the same clock.
      if (state_d == DRIVE) begin
         row_d = pick(active_d, col);
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         cnt         <= '0;
         col_q       <= '0;
         active      <= '0;
         shadow      <= '0;
         pending     <= 1'b0;
         row_q       <= '0;
         frame_start <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         col_q       <= col;
         row_q       <= row_d;
         frame_start <= boundary;
         if (swap) begin
            active  <= shadow;
            pending <= 1'b0;
         end else if (accept) begin
            shadow  <= load_data;
            pending <= 1'b1;
         end
      end
   end

`ifdef MATRIX_ROW_ACTIVE_LOW_EN
   assign row = ~row_q;
`else
   assign row = row_q;
`endif

endmodule

// File: tb/tb_matrix_row_driver.sv
// Self-checking bench for matrix_row_driver (segment table + scoreboard).
module tb_matrix_row_driver;

   localparam int ROWS = 7;
   localparam int NB   = 2;
   localparam int NSEG = 23;
   localparam int SPLIT = 16;

   logic              clock = 1'b0;
   logic              reset;
   logic [2:0]        col;
   logic              load_valid;
   logic [3*ROWS-1:0] load_data;
   logic              load_ready;
   logic [ROWS-1:0]   row;
   logic              frame_start;
   logic              blanking;

   always #5 clock = ~clock;

   matrix_row_driver #(
      .ROWS(ROWS),
      .BLANK_CYCLES(NB)
   ) dut (
      .clock(clock),
      .reset(reset),
      .col(col),
      .load_valid(load_valid),
      .load_data(load_data),
      .load_ready(load_ready),
      .row(row),
      .frame_start(frame_start),
      .blanking(blanking)
   );

   typedef struct {
      logic [6:0] row;
      logic       blank;
      logic       ready;
      logic       fs;
   } exp_t;

   typedef struct {
      logic        rst;
      logic [2:0]  col;
      int          n;
      int          lv_from;
      logic [20:0] ld;
      logic [6:0]  slice;
      logic        rdy0;
      int          rdy_drop;
      logic        fs;
      logic        idle;
   } seg_t;

   exp_t sbq[$];
   seg_t tbl[NSEG];
   int   passed = 0;
   int   total  = 0;

   localparam logic [20:0] P1 = {7'h41, 7'h22, 7'h1C};
   localparam logic [20:0] P2 = {7'h7F, 7'h55, 7'h2A};
   localparam logic [20:0] P3 = {7'h11, 7'h33, 7'h66};
   localparam logic [20:0] P4 = {7'h0F, 7'h70, 7'h3C};
   localparam logic [20:0] P5 = {7'h01, 7'h02, 7'h03};

   function automatic logic [6:0] phys(input logic [6:0] v);
`ifdef MATRIX_ROW_ACTIVE_LOW_EN
      phys = ~v;
`else
      phys = v;
`endif
   endfunction

   function automatic seg_t mk(
      input logic rst, input logic [2:0] c, input int n,
      input int lvf, input logic [20:0] ld, input logic [6:0] s,
      input logic r0, input int rd, input logic fs, input logic idle
   );
      seg_t t;
      t.rst = rst; t.col = c; t.n = n; t.lv_from = lvf; t.ld = ld;
      t.slice = s; t.rdy0 = r0; t.rdy_drop = rd; t.fs = fs;
      t.idle = idle;
      return t;
   endfunction

   task automatic chk(input string nm, input int act, input int req);
      total++;
      if (act == req) passed++;
      else $display("FAIL %s: got %0h, want %0h", nm, act, req);
   endtask

   task automatic cyc(
      input logic r, input logic [2:0] c, input logic lv,
      input logic [20:0] ld, input logic [6:0] erow,
      input logic eb, input logic er, input logic ef, input string tag
   );
      exp_t e;
      reset = r; col = c; load_valid = lv; load_data = ld;
      e.row = phys(erow); e.blank = eb; e.ready = er; e.fs = ef;
      sbq.push_back(e);
      @(posedge clock);
      #1;
      e = sbq.pop_front();
      chk({tag, " row"},   int'(row),         int'(e.row));
      chk({tag, " blank"}, int'(blanking),    int'(e.blank));
      chk({tag, " ready"}, int'(load_ready),  int'(e.ready));
      chk({tag, " fs"},    int'(frame_start), int'(e.fs));
   endtask

   task automatic run_seg(input seg_t s, input int idx);
      for (int i = 0; i < s.n; i++) begin
         logic       lv;
         logic       off;
         logic       er;
         lv  = (s.lv_from >= 0) && (i >= s.lv_from);
         off = s.rst || s.idle || (i < NB);
         er  = (s.rdy_drop >= 0 && i >= s.rdy_drop) ? 1'b0 : s.rdy0;
         cyc(s.rst, s.col, lv, s.ld, off ? 7'h00 : s.slice, off, er,
             (i == 0) ? s.fs : 1'b0, $sformatf("seg%0d.%0d", idx, i));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: got running, want finished");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0]  = mk(0, 3'b100, 8,  4, P1, 7'h00, 1,  4, 1, 0);
      tbl[1]  = mk(0, 3'b010, 8, -1, P1, 7'h00, 0, -1, 0, 0);
      tbl[2]  = mk(0, 3'b001, 8, -1, P1, 7'h00, 0, -1, 0, 0);
      tbl[3]  = mk(0, 3'b100, 8, -1, P1, 7'h41, 1, -1, 1, 0);
      tbl[4]  = mk(0, 3'b010, 8, -1, P1, 7'h22, 1, -1, 0, 0);
      tbl[5]  = mk(0, 3'b001, 8, -1, P1, 7'h1C, 1, -1, 0, 0);
      tbl[6]  = mk(0, 3'b100, 8, -1, P1, 7'h41, 1, -1, 1, 0);
      tbl[7]  = mk(0, 3'b010, 4,  0, P2, 7'h22, 1,  0, 0, 0);
      tbl[8]  = mk(0, 3'b001, 4,  0, P3, 7'h1C, 0, -1, 0, 0);
      tbl[9]  = mk(0, 3'b100, 4,  0, P3, 7'h7F, 1,  1, 1, 0);
      tbl[10] = mk(0, 3'b010, 4, -1, P3, 7'h55, 0, -1, 0, 0);
      tbl[11] = mk(0, 3'b100, 4, -1, P3, 7'h11, 1, -1, 1, 0);
      tbl[12] = mk(0, 3'b010, 4, -1, P3, 7'h33, 1, -1, 0, 0);
      tbl[13] = mk(0, 3'b100, 4,  0, P4, 7'h11, 1,  0, 1, 0);
      tbl[14] = mk(0, 3'b001, 4, -1, P4, 7'h66, 0, -1, 0, 0);
      tbl[15] = mk(0, 3'b100, 4, -1, P4, 7'h0F, 1, -1, 1, 0);
      tbl[16] = mk(0, 3'b011, 2, -1, P4, 7'h00, 1, -1, 0, 1);
      tbl[17] = mk(0, 3'b000, 2, -1, P4, 7'h00, 1, -1, 0, 1);
      tbl[18] = mk(0, 3'b010, 4, -1, P4, 7'h70, 1, -1, 0, 0);
      tbl[19] = mk(0, 3'b001, 4,  2, P5, 7'h3C, 1,  2, 0, 0);
      tbl[20] = mk(1, 3'b001, 1, -1, P5, 7'h00, 1, -1, 0, 0);
      tbl[21] = mk(0, 3'b100, 4, -1, P5, 7'h00, 1, -1, 1, 0);
      tbl[22] = mk(0, 3'b010, 4, -1, P5, 7'h00, 1, -1, 0, 0);

      reset = 1'b1; col = 3'b100; load_valid = 1'b0; load_data = '0;
      cyc(1, 3'b100, 0, '0, 7'h00, 1, 1, 0, "reset0");
      cyc(1, 3'b100, 0, '0, 7'h00, 1, 1, 0, "reset1");

      for (int k = 0; k < SPLIT; k++) run_seg(tbl[k], k);

      // Column change one cycle into blanking restarts the gap.
      cyc(0, 3'b010, 0, '0, 7'h00, 1, 1, 0, "restart0");
      cyc(0, 3'b001, 0, '0, 7'h00, 1, 1, 0, "restart1");
      cyc(0, 3'b001, 0, '0, 7'h00, 1, 1, 0, "restart2");
      cyc(0, 3'b001, 0, '0, 7'h3C, 0, 1, 0, "restart3");
      cyc(0, 3'b001, 0, '0, 7'h3C, 0, 1, 0, "restart4");

      for (int k = SPLIT; k < NSEG; k++) run_seg(tbl[k], k);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/matrix_row_driver.md
Name: matrix_row_driver

Overview:
Downstream consumer of the 3-bit one-hot column selector of the 5-column LED matrix; drives the row lines for whichever mirrored column pair is active.
- Holds a double-buffered 3-column × ROWS-row pattern (columns 0/4 and 1/3 are mirrored, so 3 slices cover all 5 columns).
- Inserts a blanking gap on every column change to prevent ghosting.
- Swaps in newly loaded patterns only at frame boundaries, so a displayed frame never tears.

Parameters:
ROWS, 7, number of matrix rows (row bits per column slice).
BLANK_CYCLES, 2, clocks with all rows off after each column change (0 allowed = no blanking).

Ports:
clock  input  1  system clock, all logic on rising edge.
reset  input  1  synchronous, active-high reset.
col  input  3  one-hot column select from column selector (col[2]=cols 0/4, col[1]=cols 1/3, col[0]=col 2).
load_valid  input  1  new pattern offered.
load_data  input  3*ROWS  pattern; slice k = load_data[k*ROWS +: ROWS] drives rows while col[k]=1.
load_ready  output  1  shadow buffer free; load accepted when load_valid & load_ready.
row  output  ROWS  row drive, logical 1 = LED on (polarity per optional feature).
frame_start  output  1  one-cycle pulse at frame boundary.
blanking  output  1  high while rows are forced off (BLANK or IDLE state).

Behaviour:
- Reset (synchronous): row=all off, state=IDLE, active buffer=0, shadow=0, pending=0, load_ready=1, frame_start=0, blanking=1, col_q=0, blank counter=0. A reset mid-frame discards a pending pattern.
- col is registered each cycle into col_q. Definitions:
  - valid = col is exactly one-hot.
  - change = valid && (col != col_q).
  - boundary = change && col==3'b100.
- State machine:
  - IDLE: rows off. On change → BLANK (or DRIVE if BLANK_CYCLES=0). Any non-one-hot col (000, 011, 111, …) forces IDLE from any state, next cycle.
  - BLANK: rows off; counter loads BLANK_CYCLES-1 on entry and decrements. Counter at 0 → DRIVE. Another change during BLANK reloads the counter and stays in BLANK.
  - DRIVE: row = active slice selected by col_q. Change → BLANK. Stable valid col → stay.
- Latency:
  - col change sampled at edge t → rows off from t+1 through t+BLANK_CYCLES.
  - New column data appears at t+1+BLANK_CYCLES; with BLANK_CYCLES=0 it appears at t+1.
- frame_start: registered, high exactly one cycle (edge t+1) after a boundary sample.
- Load handshake:
  - load_ready = !pending (registered).
  - On accept: shadow←load_data, pending←1.
  - load_data is ignored when load_ready=0. load_valid may be held; no accept until ready returns.
- Swap:
  - On boundary && pending: active←shadow, pending←0. The new pattern takes effect for the whole frame starting at col[2].
  - load_ready rises the cycle after the swap.
- Accept and boundary in the same cycle with pending=0: data goes to shadow only; the swap waits for the next boundary.
- Column order is not checked. Any valid change is honoured, and only the 3'b100 entry defines a boundary.
- row is fully registered; no combinational path from col to row.

Optional Feature:
Macro MATRIX_ROW_ACTIVE_LOW_EN.
- Defined: physical row output is inverted (0 = LED on, all-off = all ones), including the reset value.
- Undefined: row is active-high, all-off = all zeros.
- Internal logic, blanking, and handshake are identical in both builds.

Test Plan:
- Reset held 2 cycles with col=100 → row=0, blanking=1, load_ready=1, frame_start=0. Release → blanking for 2 cycles, then row=active slice 2 =0.
- Load load_data={7'h41,7'h22,7'h1C} while col cycles 100→010→001 (stable 8 clocks each) → swap at next 100. row reads 0x41, 0x22, 0x1C in turn, each after exactly 2 blank cycles; frame_start pulses once per frame.
- Second load_valid while pending → load_ready=0, no accept. At boundary, ready=1 one cycle after the swap, and the held data is then accepted.
- col toggles 010→001 during blanking (1 cycle into BLANK) → counter restarts; rows stay off 2 more cycles, then show slice 0.
- col=011 then 000 while in DRIVE → row off and blanking=1 next cycle. Return to 010 → 2 blank cycles, then slice 1.
- Build with MATRIX_ROW_ACTIVE_LOW_EN and repeat test 2 → row values bit-inverted (0x3E, 0x5D, 0x63); reset/blank value 0x7F.
